// File: rtl/bs_pkg.sv
// Shared definitions for the bus scheduler: packet field positions, broadcast
// code and the sequencer state encoding.
package bs_pkg;
    // Field positions are measured down from the packet MSB so they hold for any PCKG_SZ.
    localparam int TGT_MSB = 0;
    localparam int SRC_MSB = 8;
    localparam int ID_MSB  = 16;

    localparam logic [7:0] BROADCAST_DEF = 8'hFF;

    typedef enum logic [1:0] {IDLE, POP, SEND, PUSH} state_e;
endpackage

// File: rtl/bs_rr_scheduler_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr,
// wrapping modulo N.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] g
);
    logic [IW-1:0] idx;

    // Scan from farthest to nearest so the nearest request wins.
    always_comb begin
        valid = 1'b0;
        g     = '0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            idx = IW'((int'(ptr) + i) % N);
            if (req[idx]) begin
                valid = 1'b1;
                g     = idx;
            end
        end
    end
endmodule

// File: rtl/bs_rr_scheduler.sv
// Central bus sequencer: grants one pending driver FIFO in round-robin order,
// pops its packet, decodes the target and pushes it to the destination(s).
module bs_rr_scheduler
    import bs_pkg::*;
#(
    parameter int         DRVRS     = 4,
    parameter int         PCKG_SZ   = 32,
    parameter logic [7:0] BROADCAST = BROADCAST_DEF,
    localparam int        IW        = (DRVRS > 1) ? $clog2(DRVRS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DRVRS-1:0]                pndng,
    input  logic [DRVRS-1:0][PCKG_SZ-1:0]   D_pop,
    input  logic [DRVRS-1:0]                full,
    output logic [DRVRS-1:0]                pop,
    output logic [DRVRS-1:0]                push,
    output logic [DRVRS-1:0][PCKG_SZ-1:0]   D_push,
    output logic [7:0]                      grant_id,
    output logic                            busy,
    output logic                            drop_err,
    output logic [15:0]                     pkt_cnt
);
    state_e               state_q, state_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PCKG_SZ-1:0]   pkt_q, pkt_d;
    logic [PCKG_SZ-1:0]   d_push_q, d_push_d;
    logic [DRVRS-1:0]     dst_mask_q, dst_mask_d;
    logic [DRVRS-1:0]     pop_q, pop_d;
    logic [DRVRS-1:0]     push_q, push_d;
    logic [7:0]           grant_id_q, grant_id_d;
    logic                 busy_q, busy_d;
    logic                 drop_err_q, drop_err_d;
    logic [15:0]          pkt_cnt_q, pkt_cnt_d;

    logic                 arb_vld;
    logic [IW-1:0]        arb_g;
    logic [7:0]           tgt;
    logic                 dec_vld;
    logic [DRVRS-1:0]     dec_mask;

    rr_arbiter #(.N(DRVRS)) u_arb (
        .req   (pndng),
        .ptr   (rr_ptr_q),
        .valid (arb_vld),
        .g     (arb_g)
    );

    // rr_ptr_q still holds the granted source while the packet is decoded.
    assign tgt = pkt_q[PCKG_SZ-1-TGT_MSB -: 8];

    always_comb begin
        dec_vld  = 1'b0;
        dec_mask = '0;
        if (tgt == BROADCAST) begin
            dec_vld  = 1'b1;
            dec_mask = ~(DRVRS'(1) << rr_ptr_q);
        end else if (int'(tgt) < DRVRS) begin
            dec_vld  = 1'b1;
            dec_mask = DRVRS'(1) << tgt;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        pkt_d      = pkt_q;
        d_push_d   = d_push_q;
        dst_mask_d = dst_mask_q;
        pop_d      = '0;
        push_d     = '0;
        grant_id_d = grant_id_q;
        drop_err_d = 1'b0;
        pkt_cnt_d  = pkt_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (arb_vld) begin
                    grant_id_d = 8'(arb_g);
                    pkt_d      = D_pop[arb_g];
                    pop_d      = DRVRS'(1) << arb_g;
                    rr_ptr_d   = arb_g;
                    state_d    = POP;
                end
            end
            POP: begin
                if (dec_vld) begin
                    dst_mask_d = dec_mask;
                    state_d    = SEND;
                end else begin
                    drop_err_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            SEND: begin
                // All destinations must have room at once; no partial broadcast.
                if ((dst_mask_q & full) == '0) begin
                    push_d   = dst_mask_q;
                    d_push_d = pkt_q;
                    state_d  = PUSH;
                end
            end
            PUSH: begin
                pkt_cnt_d = pkt_cnt_q + 16'd1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= IW'(DRVRS - 1);
            pkt_q      <= '0;
            d_push_q   <= '0;
            dst_mask_q <= '0;
            pop_q      <= '0;
            push_q     <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            drop_err_q <= 1'b0;
            pkt_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            pkt_q      <= pkt_d;
            d_push_q   <= d_push_d;
            dst_mask_q <= dst_mask_d;
            pop_q      <= pop_d;
            push_q     <= push_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            drop_err_q <= drop_err_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = {DRVRS{d_push_q}};
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign drop_err = drop_err_q;
    assign pkt_cnt  = pkt_cnt_q;
endmodule
